// File: rtl/medidor_pkg.sv
// medidor_pkg: shared types and default sizes for the pulse-width meter.
// State encoding is fixed so it can be observed on a debug bus.
package medidor_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      MEDIR       = 2'd1,
      ESPERA_BAJO = 2'd2
   } estado_t;

   localparam int ANCHO_W       = 18;
   localparam int SYNC_DEF      = 2;
   localparam int MIN_ANCHO_DEF = 2;

endpackage

// File: rtl/sincronizador_flanco.sv
// sincronizador_flanco: multi-flop synchroniser for an async input,
// preset to 1 on reset, with registered rise/fall detection.
module sincronizador_flanco
   import medidor_pkg::*;
#(
   parameter int SYNC = SYNC_DEF
) (
   input  logic Clk,
   input  logic Clr_n,
   input  logic Din,
   output logic ms,
   output logic sube,
   output logic baja
);

   logic [SYNC-1:0] sync_q;
   logic [SYNC-1:0] sync_d;
   logic            ms_raw;
   logic            ms_d_q;
   logic            ms_d_d;
   logic            sube_q;
   logic            sube_d;
   logic            baja_q;
   logic            baja_d;

   // ms is the delayed copy so it stays aligned with the registered edges
   always_comb begin
      sync_d = {sync_q[SYNC-2:0], Din};
      ms_raw = sync_q[SYNC-1];
      ms_d_d = ms_raw;
      sube_d = ms_raw & ~ms_d_q;
      baja_d = ~ms_raw & ms_d_q;
   end

   always_ff @(posedge Clk or negedge Clr_n) begin
      if (!Clr_n) begin
         sync_q <= '1;
         ms_d_q <= 1'b1;
         sube_q <= 1'b0;
         baja_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         ms_d_q <= ms_d_d;
         sube_q <= sube_d;
         baja_q <= baja_d;
      end
   end

   assign ms   = ms_d_q;
   assign sube = sube_q;
   assign baja = baja_q;

endmodule

// File: rtl/medidor_pulso.sv
// medidor_pulso: measures the high time of an async one-shot in Clk
// cycles, strobing Listo on a valid width and Glitch on a short one.
module medidor_pulso
   import medidor_pkg::*;
#(
   parameter int W         = ANCHO_W,
   parameter int SYNC      = SYNC_DEF,
   parameter int MIN_ANCHO = MIN_ANCHO_DEF
) (
   input  logic         Clk,
   input  logic         Clr_n,
   input  logic         Mi,
   input  logic         En,
   output logic [W-1:0] Ancho,
   output logic         Listo,
   output logic         Desborde,
   output logic         Glitch,
   output logic         Ocupado
);

   localparam logic [W-1:0] CNT_MAX = '1;
   localparam logic [W-1:0] CNT_UNO = W'(1);
   localparam logic [W-1:0] CNT_MIN = W'(MIN_ANCHO);

   logic ms;
   logic sube;
   logic baja;

   estado_t      estado_q;
   estado_t      estado_d;
   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic [W-1:0] ancho_q;
   logic [W-1:0] ancho_d;
   logic         listo_q;
   logic         listo_d;
   logic         desb_q;
   logic         desb_d;
   logic         glitch_q;
   logic         glitch_d;
   logic         ocup_q;
   logic         ocup_d;

   sincronizador_flanco #(
      .SYNC (SYNC)
   ) u_sinc (
      .Clk   (Clk),
      .Clr_n (Clr_n),
      .Din   (Mi),
      .ms    (ms),
      .sube  (sube),
      .baja  (baja)
   );

   always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q;
      ancho_d  = ancho_q;
      listo_d  = 1'b0;
      desb_d   = desb_q;
      glitch_d = 1'b0;
      unique case (estado_q)
         IDLE: begin
            if (sube && En) begin
               cnt_d    = CNT_UNO;
               desb_d   = 1'b0;
               estado_d = MEDIR;
            end
         end
         MEDIR: begin
            if (baja) begin
               if (cnt_q >= CNT_MIN) begin
                  ancho_d = cnt_q;
                  listo_d = 1'b1;
               end else begin
                  glitch_d = 1'b1;
               end
               estado_d = IDLE;
            end else if (ms) begin
               // saturate instead of wrapping; report once, then wait low
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_UNO;
               end else begin
                  ancho_d  = CNT_MAX;
                  desb_d   = 1'b1;
                  listo_d  = 1'b1;
                  estado_d = ESPERA_BAJO;
               end
            end
         end
         ESPERA_BAJO: begin
            if (baja) begin
               estado_d = IDLE;
            end
         end
         default: begin
            estado_d = IDLE;
         end
      endcase
      ocup_d = (estado_d != IDLE);
   end

   always_ff @(posedge Clk or negedge Clr_n) begin
      if (!Clr_n) begin
         estado_q <= IDLE;
         cnt_q    <= '0;
         ancho_q  <= '0;
         listo_q  <= 1'b0;
         desb_q   <= 1'b0;
         glitch_q <= 1'b0;
         ocup_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
         ancho_q  <= ancho_d;
         listo_q  <= listo_d;
         desb_q   <= desb_d;
         glitch_q <= glitch_d;
         ocup_q   <= ocup_d;
      end
   end

   assign Ancho    = ancho_q;
   assign Listo    = listo_q;
   assign Desborde = desb_q;
   assign Glitch   = glitch_q;
   assign Ocupado  = ocup_q;

endmodule

// File: tb/tb_medidor_pulso.sv
// tb_medidor_pulso: directed pulses with a scoreboard of expected
// Listo/Glitch events (value and arrival cycle) per instance.
module tb_medidor_pulso;

   localparam int SYNC = 2;
   localparam int W_B  = 4;

   typedef struct {
      bit g;
      int anc;
      bit d;
      int cyc;
   } ev_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic        clr_a, mi_a, en_a;
   logic [17:0] ancho_a;
   logic        listo_a, desb_a, glitch_a, ocup_a;

   logic        clr_b, mi_b, en_b;
   logic [3:0]  ancho_b;
   logic        listo_b, desb_b, glitch_b, ocup_b;

   ev_t q_a[$];
   ev_t q_b[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   medidor_pulso #(.W(18), .SYNC(SYNC), .MIN_ANCHO(2)) dut_a (
      .Clk(clk), .Clr_n(clr_a), .Mi(mi_a), .En(en_a),
      .Ancho(ancho_a), .Listo(listo_a), .Desborde(desb_a),
      .Glitch(glitch_a), .Ocupado(ocup_a)
   );

   medidor_pulso #(.W(W_B), .SYNC(SYNC), .MIN_ANCHO(2)) dut_b (
      .Clk(clk), .Clr_n(clr_b), .Mi(mi_b), .En(en_b),
      .Ancho(ancho_b), .Listo(listo_b), .Desborde(desb_b),
      .Glitch(glitch_b), .Ocupado(ocup_b)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cyc %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic push(input int idx, input bit g, input int anc,
                       input bit d, input int c);
      ev_t e;
      e.g = g; e.anc = anc; e.d = d; e.cyc = c;
      if (idx == 0) q_a.push_back(e);
      else q_b.push_back(e);
   endtask

   task automatic mon(input int idx, input logic listo,
                      input logic glitch, input logic [17:0] anc,
                      input logic desb);
      ev_t   e;
      string p;
      int    n;
      p = (idx == 0) ? "a_" : "b_";
      n = (idx == 0) ? q_a.size() : q_b.size();
      if (listo || glitch) begin
         chk({p, "exclusivos"}, {31'd0, listo & glitch}, 32'd0);
         checks++;
         if (n == 0) begin
            errors++;
            $display("FAIL %sinesperado actual=listo%0d/glitch%0d expected=none (cyc %0d)",
                     p, listo, glitch, cyc);
         end else begin
            e = (idx == 0) ? q_a.pop_front() : q_b.pop_front();
            chk({p, "tipo_glitch"}, {31'd0, glitch}, {31'd0, e.g});
            chk({p, "ancho"}, {14'd0, anc}, e.anc);
            if (!e.g) chk({p, "desborde"}, {31'd0, desb}, {31'd0, e.d});
            chk({p, "ciclo"}, cyc, e.cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, listo_a, glitch_a, ancho_a, desb_a);
      mon(1, listo_b, glitch_b, {14'd0, ancho_b}, desb_b);
   end

   task automatic set_mi(input int idx, input logic v);
      if (idx == 0) mi_a = v;
      else mi_b = v;
   endtask

   // kind: 0 none, 1 Listo, 2 Glitch; called and returns on a negedge
   task automatic pulso(input int idx, input int n, input int gap,
                        input int kind, input int anc);
      if (kind != 0) push(idx, kind == 2, anc, 1'b0, cyc + n + SYNC + 2);
      set_mi(idx, 1'b1);
      repeat (n) @(negedge clk);
      set_mi(idx, 1'b0);
      repeat (gap) @(negedge clk);
   endtask

   int t0;

   initial begin
      clr_a = 1'b0; mi_a = 1'b1; en_a = 1'b1;
      clr_b = 1'b0; mi_b = 1'b0; en_b = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ancho", {14'd0, ancho_a}, 0);
      chk("rst_listo", {31'd0, listo_a}, 0);
      chk("rst_desb", {31'd0, desb_a}, 0);
      chk("rst_glitch", {31'd0, glitch_a}, 0);
      chk("rst_ocup", {31'd0, ocup_a}, 0);
      chk("rst_b_ancho", {28'd0, ancho_b}, 0);
      clr_a = 1'b1; clr_b = 1'b1;

      repeat (30) @(negedge clk);
      chk("mi_alto_en_reset_ocup", {31'd0, ocup_a}, 0);
      mi_a = 1'b0;
      repeat (5) @(negedge clk);

      pulso(0, 10, 5, 1, 10);
      chk("ancho_10", {14'd0, ancho_a}, 10);
      pulso(0, 1, 6, 2, 10);
      chk("ancho_tras_glitch", {14'd0, ancho_a}, 10);
      pulso(0, 7, 1, 1, 7);
      pulso(0, 9, 6, 1, 9);
      chk("ancho_9", {14'd0, ancho_a}, 9);

      en_a = 1'b0; mi_a = 1'b1;
      repeat (6) @(negedge clk);
      en_a = 1'b1;
      repeat (4) @(negedge clk);
      chk("en_tarde_ocup", {31'd0, ocup_a}, 0);
      mi_a = 1'b0;
      repeat (6) @(negedge clk);

      push(0, 1'b0, 12, 1'b0, cyc + 12 + SYNC + 2);
      mi_a = 1'b1;
      repeat (6) @(negedge clk);
      en_a = 1'b0;
      repeat (6) @(negedge clk);
      mi_a = 1'b0;
      repeat (6) @(negedge clk);
      en_a = 1'b1;
      chk("en_caido_ancho", {14'd0, ancho_a}, 12);

      mi_a = 1'b1;
      repeat (9) @(negedge clk);
      chk("medir_ocup", {31'd0, ocup_a}, 1);
      clr_a = 1'b0;
      #1;
      chk("clr_ancho", {14'd0, ancho_a}, 0);
      chk("clr_ocup", {31'd0, ocup_a}, 0);
      chk("clr_desb", {31'd0, desb_a}, 0);
      chk("clr_listo", {31'd0, listo_a}, 0);
      @(negedge clk);
      clr_a = 1'b1;
      repeat (3) @(negedge clk);
      mi_a = 1'b0;
      repeat (5) @(negedge clk);
      pulso(0, 8, 6, 1, 8);
      chk("ancho_8", {14'd0, ancho_a}, 8);

      t0 = cyc;
      push(1, 1'b0, 15, 1'b1, t0 + SYNC + 1 + (1 << W_B));
      mi_b = 1'b1;
      repeat (20) @(negedge clk);
      chk("sat_ocup", {31'd0, ocup_b}, 1);
      chk("sat_ancho", {28'd0, ancho_b}, 15);
      mi_b = 1'b0;
      repeat (6) @(negedge clk);
      chk("sat_ocup_fin", {31'd0, ocup_b}, 0);
      chk("sat_desb_mantenido", {31'd0, desb_b}, 1);
      pulso(1, 5, 6, 1, 5);
      chk("b_desb_limpio", {31'd0, desb_b}, 0);

      repeat (10) @(negedge clk);
      chk("cola_a_vacia", q_a.size(), 0);
      chk("cola_b_vacia", q_b.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/medidor_pulso.md
Name: medidor_pulso

Overview:
- Receiving end of the timed-pulse path: measures the width, in Clk cycles, of an incoming one-shot pulse, such as the delayed Mo pulse from the pulse-delay counters.
- Synchronises the asynchronous input, counts while it is high, and reports the width with a one-cycle Listo strobe.
- Flags pulses that are too short (glitches) and pulses that overflow the counter.
- Sits between the pulse generators and the 7-segment display / adder result path.

Parameters:
W, 18, width of the measurement counter and of Ancho (matches the 18-stage delay chain)
SYNC, 2, number of synchroniser flip-flops on Mi (minimum 2)
MIN_ANCHO, 2, minimum accepted width in cycles; narrower pulses are reported as Glitch

Ports:
Clk  in  1  system clock, rising edge
Clr_n  in  1  asynchronous active-low reset
Mi  in  1  asynchronous pulse input to be measured
En  in  1  arms measurement; only gates the start of a new measurement
Ancho  out  W  last accepted pulse width in Clk cycles; held until the next Listo
Listo  out  1  one-cycle strobe: Ancho/Desborde updated this cycle
Desborde  out  1  last measurement saturated; valid with Listo, held until the next measurement start
Glitch  out  1  one-cycle strobe: pulse shorter than MIN_ANCHO discarded
Ocupado  out  1  high while in MEDIR or ESPERA_BAJO

Behaviour:
- Reset (Clr_n=0, asynchronous): Ancho=0, Listo=0, Desborde=0, Glitch=0, Ocupado=0, counter=0, state=IDLE.
- Reset: synchroniser stages and the previous-sample register are preset to 1. A Mi already high at reset release gives no rising edge; Mi must go low first.
- Synchroniser: Mi passes through SYNC flops to give ms. Edge detect compares ms with the registered ms_d: sube = ms & ~ms_d; baja = ~ms & ms_d.
- State IDLE: if sube & En, then cnt<=1, Desborde<=0, go to MEDIR. sube with En=0 is ignored, and so is the remainder of that pulse.
- State MEDIR, while ms=1:
  - If cnt < 2^W-1: cnt<=cnt+1.
  - If cnt == 2^W-1: Ancho<=2^W-1, Desborde<=1, Listo pulses, go to ESPERA_BAJO.
- State MEDIR, on baja:
  - If cnt >= MIN_ANCHO: Ancho<=cnt, Listo pulses, go to IDLE.
  - Otherwise: Glitch pulses, Ancho unchanged, go to IDLE.
- State ESPERA_BAJO: on baja, go to IDLE. No strobe.
- Measured value: equals the number of Clk cycles ms was high. No off-by-one; a 1-cycle-high ms gives cnt=1.
- Latency: Listo asserts SYNC+1 Clk cycles after the first Clk edge sampling Mi low.
- Back-to-back pulses: IDLE is entered the same cycle as Listo, so a rise seen the next cycle starts a new measurement. The minimum low gap is 1 synchronised cycle.
- En deasserted during MEDIR: the measurement completes normally.
- Listo and Glitch are mutually exclusive; at most one asserts per cycle.
- Counter arithmetic: unsigned W bits, saturating, never wraps.
- Reset mid-measurement: abandons the measurement with no strobe; all outputs go to their reset values.

Decomposition:
- Shared package (medidor_pkg): state encoding (IDLE=2'd0, MEDIR=2'd1, ESPERA_BAJO=2'd2) and default width constant ANCHO_W=18.
- One sub-module, sincronizador_flanco: an SYNC-deep 2FF-style synchroniser with preset-to-1 reset and registered edge detect. It outputs ms, sube and baja, and is reused for other asynchronous inputs (push-buttons).
- The FSM, counter and output registers live in medidor_pulso.

Test Plan:
- Reset release with Mi=1, En=1, then hold Mi high 30 cycles and drop it -> no Listo, no Glitch. Next Mi pulse high 10 cycles -> Listo once, Ancho=10, Desborde=0.
- En=1, Mi high 1 cycle (MIN_ANCHO=2) -> Glitch one cycle, Listo=0, Ancho keeps previous value.
- Override W=4: Mi high 20 cycles -> Listo at count 15, Ancho=15, Desborde=1, Ocupado high until Mi low. No second strobe; the next 5-cycle pulse gives Ancho=5, Desborde=0.
- Pulses of 7 and 9 cycles separated by 1 low cycle -> two Listo strobes, Ancho=7 then 9. Each Listo lands SYNC+1 cycles after the corresponding Mi fall.
- En=0 at rise, En=1 mid-pulse -> no measurement. Conversely, En=1 at rise and dropped mid-pulse of 12 cycles -> Ancho=12.
- Clr_n pulsed low during MEDIR at cnt=6 -> all outputs 0 immediately, no Listo. The next full 8-cycle pulse gives Ancho=8.
